vco_sweep_ctrl: RTL and testbench

VCO_SWEEP_CTRL -- requirements
Module: vco_sweep_ctrl

---
 rtl/vco_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_vco_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vco_sweep_ctrl.sv
// VCO sweep controller: settles the DAC on START_CODE, then steps toward STOP_CODE with a per-code dwell.
// Define SWEEP_TRIANGLE_EN to return to START_CODE after STOP_CODE (triangle sweep).
module vco_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned DWELL_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] dac_code,
  output logic       dac_en,
  output logic       mix_en,
  output logic       busy,
  output logic       step_stb,
  output logic       done
);
  localparam int unsigned CODE_W = 8;
`ifdef SWEEP_TRIANGLE_EN
  localparam bit TRI_EN = 1'b1;
`else
  localparam bit TRI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_t;

  state_t              state_q;
  logic [CODE_W-1:0]   start_code_q, stop_code_q, step_q, code_q;
  logic [DWELL_W-1:0]  dwell_q, dwell_cnt_q;
  logic [7:0]          settle_cnt_q;
  logic                dir_up_q, leg_q;
  logic                dac_en_q, mix_en_q, busy_q, step_stb_q, done_q;

  logic [CODE_W-1:0]   step_eff_d, tgt_d, code_d;
  logic                up_d, turn_d, at_tgt_d;

  // Next code toward the active target; a turnaround at STOP aims at START instead.
  always_comb begin
    step_eff_d = (step_q == '0) ? CODE_W'(1) : step_q;
    turn_d     = TRI_EN && !leg_q && (code_q == stop_code_q) && (start_code_q != stop_code_q);
    at_tgt_d   = (code_q == (leg_q ? start_code_q : stop_code_q));
    if (turn_d || leg_q) begin
      tgt_d = start_code_q;
      up_d  = ~dir_up_q;
    end else begin
      tgt_d = stop_code_q;
      up_d  = dir_up_q;
    end
    if (up_d) begin
      code_d = ((tgt_d - code_q) < step_eff_d) ? tgt_d : code_q + step_eff_d;
    end else begin
      code_d = ((code_q - tgt_d) < step_eff_d) ? tgt_d : code_q - step_eff_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= '0;
      dac_en_q     <= 1'b0;
      mix_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      step_stb_q   <= 1'b0;
      done_q       <= 1'b0;
      start_code_q <= '0;
      stop_code_q  <= 8'hFF;
      step_q       <= CODE_W'(1);
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      settle_cnt_q <= '0;
      dir_up_q     <= 1'b1;
      leg_q        <= 1'b0;
    end else begin
      step_stb_q <= 1'b0;
      done_q     <= 1'b0;
      // Abort wins over everything else; the code is left where it was.
      if (abort && (state_q != IDLE)) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        dac_en_q <= 1'b0;
        mix_en_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cfg_we) begin
              case (cfg_addr)
                2'd0:    start_code_q <= cfg_data;
                2'd1:    stop_code_q  <= cfg_data;
                2'd2:    step_q       <= cfg_data;
                default: dwell_q      <= DWELL_W'(cfg_data);
              endcase
            end
            if (start && !abort) begin
              state_q      <= SETTLE;
              busy_q       <= 1'b1;
              code_q       <= start_code_q;
              dac_en_q     <= 1'b1;
              dir_up_q     <= (stop_code_q >= start_code_q);
              leg_q        <= 1'b0;
              settle_cnt_q <= 8'(SETTLE_CYC - 1);
            end
          end
          SETTLE: begin
            if (settle_cnt_q == '0) begin
              state_q     <= DWELL;
              mix_en_q    <= 1'b1;
              dwell_cnt_q <= dwell_q;
            end else begin
              settle_cnt_q <= settle_cnt_q - 8'(1);
            end
          end
          DWELL: begin
            if (dwell_cnt_q != '0) begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
            end else if (!at_tgt_d || turn_d) begin
              code_q      <= code_d;
              step_stb_q  <= 1'b1;
              dwell_cnt_q <= dwell_q;
              if (turn_d) leg_q <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              dac_en_q <= 1'b0;
              mix_en_q <= 1'b0;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dac_code = code_q;
  assign dac_en   = dac_en_q;
  assign mix_en   = mix_en_q;
  assign busy     = busy_q;
  assign step_stb = step_stb_q;
  assign done     = done_q;

endmodule

// File: tb/tb_vco_sweep_ctrl.sv
// Bench for vco_sweep_ctrl: per-cycle output trace predicted from the sweep rules,
// directed scenarios plus randomized sweeps with aborts and ignored writes.
module tb_vco_sweep_ctrl;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned DWELL_W    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] dac_code;
  logic       dac_en, mix_en, busy, step_stb, done;

  vco_sweep_ctrl #(.SETTLE_CYC(SETTLE_CYC), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .dac_code(dac_code), .dac_en(dac_en),
    .mix_en(mix_en), .busy(busy), .step_stb(step_stb), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       dac_en;
    logic       mix_en;
    logic       busy;
    logic       stb;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   codes[$];
  int   sh_start = 0, sh_stop = 255, sh_step = 1, sh_dwell = 0;
  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   pinned = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic exp_t mk(int code, bit en, bit mix, bit bsy, bit stb, bit dn);
    exp_t r;
    r.code = 8'(code); r.dac_en = en; r.mix_en = mix; r.busy = bsy; r.stb = stb; r.done = dn;
    return r;
  endfunction

  // Append the codes visited after 'from' while stepping to 'to', clamping at 'to'.
  function automatic void walk(int from, int to, int stp);
    int c = from;
    while (c != to) begin
      if (to > c) c = (to - c < stp) ? to : c + stp;
      else        c = (c - to < stp) ? to : c - stp;
      codes.push_back(c);
    end
  endfunction

  function automatic void gen_codes(int s, int e, int st);
    int stp = (st == 0) ? 1 : st;
    codes.delete();
    codes.push_back(s);
    walk(s, e, stp);
`ifdef SWEEP_TRIANGLE_EN
    if (s != e) walk(e, s, stp);
`endif
  endfunction

  // Cycle-by-cycle outputs following the edge that samples start in IDLE.
  function automatic void build_trace(int s, int e, int st, int dw);
    gen_codes(s, e, st);
    for (int i = 0; i < int'(SETTLE_CYC); i++) exp_q.push_back(mk(s, 1, 0, 1, 0, 0));
    foreach (codes[i])
      for (int k = 0; k <= dw; k++) exp_q.push_back(mk(codes[i], 1, 1, 1, (i > 0) && (k == 0), 0));
    exp_q.push_back(mk(codes[codes.size()-1], 0, 0, 1, 0, 1));
  endfunction

  function automatic int pack(int n);
    int r = 0;
    for (int i = 0; i < n && i < codes.size(); i++) r |= codes[i] << (8 * i);
    return r;
  endfunction

  function automatic void pin_model();
    int n_stb = 0, n_done = 0, first_mix = -1;
    gen_codes(10, 40, 10);
    check("pin_codes_10_40", pack(4), 32'h281E140A);
    gen_codes(200, 195, 4);
    check("pin_codes_200_195", pack(3), 32'h00C3C4C8);
    gen_codes(77, 77, 5);
    check("pin_len_77", codes.size(), 1);
    gen_codes(5, 7, 0);
    check("pin_step0", pack(3), 32'h00070605);
    gen_codes(0, 3, 2);
`ifdef SWEEP_TRIANGLE_EN
    check("pin_tri_len", codes.size(), 5);
    check("pin_tri_codes", pack(4), 32'h01030200);
    check("pin_tri_last", codes[4], 0);
`else
    check("pin_ramp_len", codes.size(), 3);
    check("pin_ramp_codes", pack(3), 32'h00030200);
`endif
    exp_q.delete();
    build_trace(10, 40, 10, 3);
    foreach (exp_q[i]) begin
      n_stb  += int'(exp_q[i].stb);
      n_done += int'(exp_q[i].done);
      if (first_mix < 0 && exp_q[i].mix_en) first_mix = i;
    end
`ifdef SWEEP_TRIANGLE_EN
    check("pin_trace_len", exp_q.size(), 45);
    check("pin_trace_stb", n_stb, 6);
`else
    check("pin_trace_len", exp_q.size(), 33);
    check("pin_trace_stb", n_stb, 3);
`endif
    check("pin_trace_done", n_done, 1);
    check("pin_trace_mix", first_mix, 16);
    exp_q.delete();
  endfunction

  function automatic int dut_vec();
    return 32'({dac_code, dac_en, mix_en, busy, step_stb, done});
  endfunction

  // Compare process: check this cycle, then advance the model with the inputs the next edge samples.
  always @(negedge clk) begin
    logic [7:0] hold;
    cyc++;
    if (!pinned) begin
      pin_model();
      pinned = 1'b1;
    end
    if (rst) begin
      exp_q.delete();
      cur = '0;
      sh_start = 0; sh_stop = 255; sh_step = 1; sh_dwell = 0;
      check("reset_outputs", dut_vec(), 0);
    end else begin
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else begin
        hold = cur.code;
        cur = '0;
        cur.code = hold;
      end
      check("outputs", dut_vec(), 32'(cur));
      if (cur.busy && abort) begin
        exp_q.delete();
      end else if (!cur.busy) begin
        if (start && !abort) build_trace(sh_start, sh_stop, sh_step, sh_dwell);
        if (cfg_we) begin
          case (cfg_addr)
            2'd0: sh_start = int'(cfg_data);
            2'd1: sh_stop  = int'(cfg_data);
            2'd2: sh_step  = int'(cfg_data);
            default: sh_dwell = (DWELL_W >= 8) ? int'(cfg_data) : int'(cfg_data) % (1 << DWELL_W);
          endcase
        end
      end
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = 8'(d);
    step_cyc();
    cfg_we = 1'b0;
  endtask

  task automatic setup(input int s, input int e, input int st, input int dw);
    cfg_wr(2'd0, s); cfg_wr(2'd1, e); cfg_wr(2'd2, st); cfg_wr(2'd3, dw);
  endtask

  task automatic launch();
    start = 1'b1;
    step_cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      if (!busy) return;
      step_cyc();
    end
    $display("FAIL wait_idle: busy=%0b after 5000 cycles, expected 0", busy);
    $fatal(1, "sweep did not finish");
  endtask

  initial begin
    int s, e, st, dw, n_done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step_cyc();

    // Ramp up, clamped ramp down, single-code sweep, triangle example.
    setup(10, 40, 10, 3);  launch(); wait_idle(); step_cyc();
    setup(200, 195, 4, 2); launch(); wait_idle(); step_cyc();
    setup(77, 77, 9, 1);   launch(); wait_idle(); step_cyc();
    setup(0, 3, 2, 0);     launch(); wait_idle(); step_cyc();

    // Abort in the second dwell cycle of code 20.
    setup(10, 40, 10, 3); launch();
    for (int i = 0; i < 200 && dac_code != 8'd20; i++) step_cyc();
    step_cyc();
    abort = 1'b1; step_cyc(); abort = 1'b0;
    wait_idle(); step_cyc();

    // STEP write while busy must not take effect.
    setup(10, 40, 10, 0); launch();
    repeat (5) step_cyc();
    cfg_wr(2'd2, 50);
    wait_idle(); step_cyc();

    // Abort with start in IDLE, then abort during SETTLE.
    start = 1'b1; abort = 1'b1; step_cyc(); start = 1'b0; abort = 1'b0; step_cyc();
    launch(); repeat (2) step_cyc();
    abort = 1'b1; step_cyc(); abort = 1'b0; step_cyc();

    // Start held high relaunches after DONE.
    setup(5, 9, 2, 1);
    start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 500 && n_done < 2; i++) begin
      if (done) n_done++;
      if (n_done < 2) step_cyc();
    end
    start = 1'b0;
    wait_idle(); step_cyc();

    // Asynchronous reset in the middle of SETTLE.
    setup(10, 40, 10, 3); launch();
    repeat (3) step_cyc();
    #1 rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    step_cyc();

    // Random sweeps with ignored writes, start noise while busy and rare aborts.
    for (int n = 0; n < 24; n++) begin
      s  = $urandom_range(0, 255);
      e  = ($urandom_range(0, 5) == 0) ? s : int'($urandom_range(0, 255));
      st = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 64));
      dw = $urandom_range(0, 2);
      setup(s, e, st, dw);
      launch();
      for (int i = 0; i < 5000 && busy; i++) begin
        start    = 1'($urandom_range(0, 1));
        abort    = ($urandom_range(0, 299) == 0);
        cfg_we   = ($urandom_range(0, 15) == 0);
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_data = 8'($urandom_range(0, 255));
        step_cyc();
      end
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      wait_idle(); step_cyc();
    end

    repeat (3) step_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
